// File: rtl/fpu_pkg.sv
// Shared types and constants for the iterative floating-point reciprocal unit.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    ITER,
    PACK,
    DONE
  } finv_state_e;

  localparam int EXP_BIAS      = 127;
  localparam int DEFAULT_ITERS = 3;

  // Q2.30 fixed-point constants: 48/17, 32/17 and 2.0
  localparam logic [31:0] SEED_C48 = 32'hB4B4_B4B4;
  localparam logic [31:0] SEED_C32 = 32'h7878_7878;
  localparam logic [31:0] Q230_TWO = 32'h8000_0000;

  function automatic int finvLatency(input int iters);
    return 2 * iters + 3;
  endfunction

  localparam int FINV_LATENCY = finvLatency(DEFAULT_ITERS);

endpackage

// File: rtl/finv_seed.sv
// Linear reciprocal seed y0 = 48/17 - 32/17*d for d in [0.5,1), d in Q0.32, y0 in Q2.30.
module finv_seed
  import fpu_pkg::*;
(
  input  logic [31:0] d_i,
  output logic [31:0] y0_o
);

  logic [63:0] scaled;
  logic [31:0] unused_low;

  // Constant multiply built as shift-and-add so the datapath keeps a single multiplier
  always_comb begin
    scaled = '0;
    for (int i = 0; i < 32; i++) begin
      if (SEED_C32[i]) begin
        scaled = scaled + ({32'h0, d_i} << i);
      end
    end
  end

  assign y0_o       = SEED_C48 - scaled[63:32];
  assign unused_low = scaled[31:0];

endmodule

// File: rtl/finv_iter.sv
// Iterative IEEE-754 single-precision reciprocal: Newton-Raphson on one shared
// 32x32 multiplier behind a valid/ready handshake with fixed latency.
module finv_iter
  import fpu_pkg::*;
#(
  parameter int ITERS = DEFAULT_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [3:0] LAST_STEP = 4'(2 * ITERS);

  finv_state_e state_q, state_d;
  logic [31:0] x_q, yAcc_q, tProd_q, result_q;
  logic        ovf_q;
  logic [3:0]  step_q;

  logic              xSign;
  logic [7:0]        xExp;
  logic [22:0]       xMant;
  logic [31:0]       dNorm, seedY, mulA, mulB;
  logic [63:0]       prod;
  logic signed [9:0] resExp;
  logic [22:0]       packMant;
  logic [31:0]       packY;
  logic              packOvf;
  logic              unused_bits;

  assign {xSign, xExp, xMant} = x_q;
  assign dNorm = {1'b1, xMant, 8'h00};

  finv_seed u_seed (
    .d_i  (dNorm),
    .y0_o (seedY)
  );

  // Even steps form t = d*y, odd steps form y*(2 - t)
  assign mulA = step_q[0] ? yAcc_q : dNorm;
  assign mulB = step_q[0] ? (Q230_TWO - tProd_q) : yAcc_q;
  assign prod = 64'(mulA) * 64'(mulB);

  assign unused_bits = ^{prod[29:0], yAcc_q[6:0], resExp[9:8]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SEED;
      SEED:    state_d = ITER;
      ITER:    if (step_q == LAST_STEP) state_d = PACK;
      PACK:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // 1/x = (1/d) * 2^(126-e); 1/d lies in (1,2) unless d is exactly 0.5
  always_comb begin
    resExp = $signed(10'(2 * EXP_BIAS)) - $signed({2'b00, xExp})
             - ((xMant != '0) ? 10'sd1 : 10'sd0);
    if ((xMant == '0) || (!yAcc_q[31] && !yAcc_q[30])) begin
      packMant = '0;
    end else if (yAcc_q[31]) begin
      packMant = '1;
    end else begin
      packMant = yAcc_q[29:7];
    end
    packY   = {xSign, resExp[7:0], packMant};
    packOvf = 1'b0;
    if (xExp == 8'h00) begin
      packY   = {xSign, 8'hFF, 23'h0};
      packOvf = 1'b1;
    end else if ((xExp == 8'hFF) || (resExp <= 10'sd0)) begin
      packY = {xSign, 31'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      yAcc_q   <= '0;
      tProd_q  <= '0;
      step_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) x_q <= x;
        SEED: begin
          yAcc_q <= seedY;
          step_q <= '0;
        end
        ITER: if (step_q != LAST_STEP) begin
          if (step_q[0]) yAcc_q <= prod[61:30];
          else           tProd_q <= prod[63:32];
          step_q <= step_q + 4'd1;
        end
        PACK: begin
          result_q <= packY;
          ovf_q    <= packOvf;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_finv_iter.sv
// Directed self-checking bench for finv_iter: exact values, special operands,
// accuracy, back-pressure, in-flight reset and back-to-back operations.
module tb_finv_iter;
  import fpu_pkg::*;

  localparam int LAT = FINV_LATENCY;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  finv_iter #(.ITERS(DEFAULT_ITERS)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer one operand, count cycles from the accept edge to out_valid, take the result
  task automatic applyStimulus(input logic [31:0] xv, input logic earlyReady,
                               output int lat, output logic [31:0] yv, output logic ovfv);
    int n;
    @(negedge clk);
    x = xv;
    in_valid = 1'b1;
    out_ready = earlyReady;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      out_ready = 1'b0;
      lat = -1;
      yv = '0;
      ovfv = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    yv = y;
    ovfv = ovf;
    if (!out_valid) lat = -1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    $display("[TB] test_reset");
    rst = 1'b1;
    in_valid = 1'b1;
    x = 32'h3F800000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_y: got %h expected 00000000", y);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_capture: busy cycles %0d expected 0", seen);
    end
  endtask

  task automatic test_exact();
    logic [31:0] xs [5] = '{32'h3F800000, 32'hC0800000, 32'h40000000, 32'h3F000000, 32'h41000000};
    logic [31:0] ys [5] = '{32'h3F800000, 32'hBE800000, 32'h3F000000, 32'h40000000, 32'h3E000000};
    int lat;
    logic [31:0] yv;
    logic ovfv;
    $display("[TB] test_exact");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(xs[i], 1'b0, lat, yv, ovfv);
      checks++;
      if (yv !== ys[i]) begin
        errors++;
        $display("[TB] FAIL exact_y[%0d]: got %h expected %h", i, yv, ys[i]);
      end
      checks++;
      if (ovfv !== 1'b0) begin
        errors++;
        $display("[TB] FAIL exact_ovf[%0d]: got %b expected 0", i, ovfv);
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("[TB] FAIL exact_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] xs [10] = '{32'h00000000, 32'h80000000, 32'h00400000, 32'h7F7FFFFF, 32'hFF800000,
                             32'h7FC00000, 32'h7F000000, 32'h7E800000, 32'h7E800001, 32'h00800000};
    logic [31:0] ys [10] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h80000000,
                             32'h00000000, 32'h00000000, 32'h00800000, 32'h00000000, 32'h7E800000};
    logic        os [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    logic [31:0] yv;
    logic ovfv;
    $display("[TB] test_special");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(xs[i], 1'b0, lat, yv, ovfv);
      checks++;
      if (yv !== ys[i]) begin
        errors++;
        $display("[TB] FAIL special_y[%0d] x=%h: got %h expected %h", i, xs[i], yv, ys[i]);
      end
      checks++;
      if (ovfv !== os[i]) begin
        errors++;
        $display("[TB] FAIL special_ovf[%0d] x=%h: got %b expected %b", i, xs[i], ovfv, os[i]);
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("[TB] FAIL special_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_accuracy();
    logic [31:0] dx [4] = '{32'h40400000, 32'h3FC00000, 32'h41200000, 32'h40E00000};
    logic [31:0] dy [4] = '{32'h3EAAAAAB, 32'h3F2AAAAB, 32'h3DCCCCCD, 32'h3E124925};
    logic [22:0] m;
    logic [63:0] q;
    logic [31:0] refY, yv, diff;
    logic ovfv;
    int lat;
    $display("[TB] test_accuracy");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dx[i], 1'b0, lat, yv, ovfv);
      diff = (yv > dy[i]) ? (yv - dy[i]) : (dy[i] - yv);
      checks++;
      if (diff > 32'd4 || ovfv !== 1'b0 || lat != LAT) begin
        errors++;
        $display("[TB] FAIL approx_directed[%0d] x=%h: got %h ovf %b lat %0d expected %h+-4 ovf 0 lat %0d",
                 i, dx[i], yv, ovfv, lat, dy[i], LAT);
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 0)      m = 23'h000001;
      else if (i == 1) m = 23'h7FFFFF;
      else if (i == 2) m = 23'h7FFFFE;
      else             m = 23'((i * 209715) + 4097);
      q = (64'd1 << 48) / {40'd0, 1'b1, m};
      q = (q + 64'd1) >> 1;
      refY = {1'b0, 8'd103, q[22:0]};
      applyStimulus({1'b0, 8'd150, m}, 1'b0, lat, yv, ovfv);
      diff = (yv > refY) ? (yv - refY) : (refY - yv);
      checks++;
      if (diff > 32'd4 || ovfv !== 1'b0 || lat != LAT) begin
        errors++;
        $display("[TB] FAIL approx_sweep m=%h: got %h ovf %b lat %0d expected %h+-4 ovf 0 lat %0d",
                 m, yv, ovfv, lat, refY, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    $display("[TB] test_backpressure");
    @(negedge clk);
    x = 32'h40000000;
    in_valid = 1'b1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_idle_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d expected %0d", n, LAT);
    end
    x = 32'h3F800000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (y !== 32'h3F000000 || ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got y=%h ovf=%b ov=%b ir=%b expected y=3f000000 ovf=0 ov=1 ir=0",
                 c, y, ovf, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_inflight();
    int seen, lat;
    logic [31:0] yv;
    logic ovfv;
    $display("[TB] test_reset_inflight");
    @(negedge clk);
    x = 32'h40400000;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rif_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rif_state: got ir=%b ov=%b y=%h ovf=%b expected ir=1 ov=0 y=00000000 ovf=0",
               in_ready, out_valid, y, ovf);
    end
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL rif_no_valid: got %0d valid cycles expected 0", seen);
    end
    applyStimulus(32'hC0800000, 1'b0, lat, yv, ovfv);
    checks++;
    if (yv !== 32'hBE800000 || ovfv !== 1'b0 || lat != LAT) begin
      errors++;
      $display("[TB] FAIL rif_next_op: got y=%h ovf=%b lat=%0d expected y=be800000 ovf=0 lat=%0d",
               yv, ovfv, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3] = '{32'h3F000000, 32'h41000000, 32'hBF800000};
    logic [31:0] ys [3] = '{32'h40000000, 32'h3E000000, 32'hBF800000};
    int lat;
    logic [31:0] yv;
    logic ovfv;
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(xs[i], 1'b1, lat, yv, ovfv);
      checks++;
      if (yv !== ys[i] || ovfv !== 1'b0 || lat != LAT) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: got y=%h ovf=%b lat=%0d expected y=%h ovf=0 lat=%0d",
                 i, yv, ovfv, lat, ys[i], LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    x = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_exact();
    test_special();
    test_accuracy();
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
